// File: rtl/vc_fifo_arbiter_pkg.sv
// Shared definitions for the virtual-channel FIFO arbiter: FSM encoding,
// default geometry and the burst counter width.
package vc_fifo_arbiter_pkg;

    localparam int DEF_NUM_VC    = 4;
    localparam int DEF_LINE_SIZE = 12;

    // Wide enough for a burst limit of up to 15.
    localparam int BURST_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_WAIT = 2'd2,
        ST_PUSH = 2'd3
    } arb_state_e;

endpackage

// File: rtl/vc_fifo_arbiter_rr_pick.sv
// Combinational round-robin search: first eligible requester strictly after
// rr_ptr, wrapping modulo NUM_VC.
module rr_pick #(
    parameter int NUM_VC = 4
) (
    input  logic [NUM_VC-1:0]         eligible,
    input  logic [$clog2(NUM_VC)-1:0] rr_ptr,
    output logic                      found,
    output logic [$clog2(NUM_VC)-1:0] index
);

    localparam int IDX_W = $clog2(NUM_VC);
    localparam logic [IDX_W:0] NUM_VC_W = (IDX_W + 1)'(NUM_VC);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;

    // Scan offsets from farthest to nearest so the nearest eligible VC wins
    always_comb begin
        found  = 1'b0;
        index  = {IDX_W{1'b0}};
        sum_s  = {(IDX_W + 1){1'b0}};
        cand_s = {IDX_W{1'b0}};
        for (int k = NUM_VC; k >= 1; k--) begin
            sum_s = {1'b0, rr_ptr} + k[IDX_W:0];
            if (sum_s >= NUM_VC_W) begin
                sum_s = sum_s - NUM_VC_W;
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDX_W-1:0];
            if (eligible[cand_s]) begin
                found = 1'b1;
                index = cand_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/vc_fifo_arbiter.sv
// Moves words from NUM_VC source FIFOs into one downstream FIFO, one word per
// four cycles, with round-robin arbitration and a bounded burst per grant.
module vc_fifo_arbiter
    import vc_fifo_arbiter_pkg::*;
#(
    parameter int NUM_VC    = DEF_NUM_VC,
    parameter int LINE_SIZE = DEF_LINE_SIZE,
    parameter int BURST_MAX = 2,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUM_VC-1:0]           src_empty,
    input  logic [NUM_VC*LINE_SIZE-1:0] src_data,
    input  logic                        dst_almost_full,
    output logic [NUM_VC-1:0]           src_pop,
    output logic                        dst_push,
    output logic [LINE_SIZE-1:0]        dst_data,
    output logic [$clog2(NUM_VC)-1:0]   grant_vc,
    output logic                        busy,
    output logic [CNT_W-1:0]            xfer_count
);

    localparam int VC_W = $clog2(NUM_VC);
    localparam logic [VC_W-1:0]    RR_INIT     = VC_W'(NUM_VC - 1);
    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(BURST_MAX);
    localparam logic [BURST_W-1:0] BURST_ONE   = {{(BURST_W - 1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE     = {{(CNT_W - 1){1'b0}}, 1'b1};
    localparam logic [NUM_VC-1:0]  POP_ONE     = {{(NUM_VC - 1){1'b0}}, 1'b1};

    arb_state_e           state_r, state_nxt_s;
    logic [VC_W-1:0]      rr_ptr_r, rr_ptr_nxt_s;
    logic [BURST_W-1:0]   burst_cnt_r, burst_cnt_nxt_s;
    logic [VC_W-1:0]      grant_vc_r, grant_vc_nxt_s;
    logic [NUM_VC-1:0]    src_pop_r, src_pop_nxt_s;
    logic                 dst_push_r, dst_push_nxt_s;
    logic [LINE_SIZE-1:0] dst_data_r, dst_data_nxt_s;
    logic                 busy_r, busy_nxt_s;
    logic [CNT_W-1:0]     xfer_count_r, xfer_count_nxt_s;

    logic [NUM_VC-1:0]    eligible_s;
    logic                 pick_found_s;
    logic [VC_W-1:0]      pick_index_s;
    logic                 keep_s;
    logic [VC_W-1:0]      start_vc_s;

    assign eligible_s = ~src_empty;
    assign keep_s     = (burst_cnt_r < BURST_LIMIT) && eligible_s[grant_vc_r];

    rr_pick #(
        .NUM_VC (NUM_VC)
    ) u_rr_pick (
        .eligible (eligible_s),
        .rr_ptr   (rr_ptr_r),
        .found    (pick_found_s),
        .index    (pick_index_s)
    );

    // Next-state and next-output logic for the transfer sequence
    always_comb begin
        state_nxt_s      = state_r;
        rr_ptr_nxt_s     = rr_ptr_r;
        burst_cnt_nxt_s  = burst_cnt_r;
        grant_vc_nxt_s   = grant_vc_r;
        src_pop_nxt_s    = {NUM_VC{1'b0}};
        dst_push_nxt_s   = 1'b0;
        dst_data_nxt_s   = dst_data_r;
        xfer_count_nxt_s = xfer_count_r;
        start_vc_s       = grant_vc_r;
        case (state_r)
            ST_IDLE: begin
                if (!pick_found_s) begin
                    // Nothing to send: make the next grant rotate.
                    burst_cnt_nxt_s = BURST_LIMIT;
                end else if (enable && !dst_almost_full) begin
                    if (keep_s) begin
                        start_vc_s      = grant_vc_r;
                        burst_cnt_nxt_s = burst_cnt_r + BURST_ONE;
                    end else begin
                        start_vc_s      = pick_index_s;
                        burst_cnt_nxt_s = BURST_ONE;
                    end
                    // rr_ptr always names the VC that owns the current burst.
                    rr_ptr_nxt_s   = start_vc_s;
                    grant_vc_nxt_s = start_vc_s;
                    src_pop_nxt_s  = POP_ONE << start_vc_s;
                    state_nxt_s    = ST_POP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_POP: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                state_nxt_s = ST_PUSH;
            end
            ST_PUSH: begin
                dst_data_nxt_s   = src_data[int'(grant_vc_r) * LINE_SIZE +: LINE_SIZE];
                dst_push_nxt_s   = 1'b1;
                xfer_count_nxt_s = xfer_count_r + CNT_ONE;
                state_nxt_s      = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Arbitration bookkeeping and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_r     <= RR_INIT;
            burst_cnt_r  <= {BURST_W{1'b0}};
            grant_vc_r   <= {VC_W{1'b0}};
            src_pop_r    <= {NUM_VC{1'b0}};
            dst_push_r   <= 1'b0;
            dst_data_r   <= {LINE_SIZE{1'b0}};
            busy_r       <= 1'b0;
            xfer_count_r <= {CNT_W{1'b0}};
        end else begin
            rr_ptr_r     <= rr_ptr_nxt_s;
            burst_cnt_r  <= burst_cnt_nxt_s;
            grant_vc_r   <= grant_vc_nxt_s;
            src_pop_r    <= src_pop_nxt_s;
            dst_push_r   <= dst_push_nxt_s;
            dst_data_r   <= dst_data_nxt_s;
            busy_r       <= busy_nxt_s;
            xfer_count_r <= xfer_count_nxt_s;
        end
    end

    assign src_pop    = src_pop_r;
    assign dst_push   = dst_push_r;
    assign dst_data   = dst_data_r;
    assign grant_vc   = grant_vc_r;
    assign busy       = busy_r;
    assign xfer_count = xfer_count_r;

endmodule

// File: tb/tb_vc_fifo_arbiter.sv
// Bench for vc_fifo_arbiter: behavioural source FIFOs plus a transaction-level
// arbitration model that predicts every downstream push.
module tb_vc_fifo_arbiter;

    localparam int NV = 4;
    localparam int LS = 12;
    localparam int BM = 2;
    localparam int CW = 5;
    localparam int VW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NV-1:0]     src_empty;
    logic [NV*LS-1:0]  src_data;
    logic              dst_almost_full;
    logic [NV-1:0]     src_pop;
    logic              dst_push;
    logic [LS-1:0]     dst_data;
    logic [VW-1:0]     grant_vc;
    logic              busy;
    logic [CW-1:0]     xfer_count;

    always #5 clk = ~clk;

    vc_fifo_arbiter #(
        .NUM_VC    (NV),
        .LINE_SIZE (LS),
        .BURST_MAX (BM),
        .CNT_W     (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .src_empty       (src_empty),
        .src_data        (src_data),
        .dst_almost_full (dst_almost_full),
        .src_pop         (src_pop),
        .dst_push        (dst_push),
        .dst_data        (dst_data),
        .grant_vc        (grant_vc),
        .busy            (busy),
        .xfer_count      (xfer_count)
    );

    typedef struct packed {
        logic [VW-1:0] vc;
        logic [LS-1:0] data;
        logic [CW-1:0] cnt;
    } rec_t;

    int total = 0;
    int bad   = 0;

    logic [LS-1:0] srcq [NV][$];
    logic [LS-1:0] mq   [NV][$];
    rec_t          push_log [$];
    rec_t          exp_q    [$];
    int            pop_cyc  [$];
    int            cyc  = 0;
    int            viol = 0;
    int            pops = 0;
    logic [NV-1:0] pop_prev = '0;

    int            m_rr, m_gv, m_bc;
    logic [CW-1:0] m_xfer;

    // One clock: source FIFOs react to last cycle's pop, outputs are observed.
    task automatic tick();
        logic          in_en, in_af;
        logic [NV-1:0] in_empty;
        rec_t          r;
        in_en    = enable;
        in_af    = dst_almost_full;
        in_empty = src_empty;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NV; i++) begin
            if (pop_prev[i]) begin
                if (srcq[i].size() > 0) src_data[i*LS +: LS] = srcq[i].pop_front();
                else viol++;
            end
        end
        for (int i = 0; i < NV; i++) src_empty[i] = (srcq[i].size() == 0);
        if (src_pop != '0) begin
            pops++;
            pop_cyc.push_back(cyc);
            if ($countones(src_pop) != 1) viol++;
            for (int i = 0; i < NV; i++)
                if (src_pop[i] && (!in_en || in_af || in_empty[i])) viol++;
            if (dst_push) viol++;
        end
        if (dst_push) begin
            r.vc   = grant_vc;
            r.data = dst_data;
            r.cnt  = xfer_count;
            push_log.push_back(r);
        end
        pop_prev = src_pop;
    endtask

    task automatic load(input int vc, input logic [LS-1:0] d);
        srcq[vc].push_back(d);
        mq[vc].push_back(d);
        src_empty[vc] = 1'b0;
    endtask

    function automatic bit model_has_words();
        for (int i = 0; i < NV; i++) if (mq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Arbitration rules applied one transfer at a time over the loaded words.
    task automatic model_predict();
        int   g;
        rec_t r;
        exp_q.delete();
        while (model_has_words()) begin
            if (m_bc < BM && mq[m_gv].size() > 0) begin
                g = m_gv;
                m_bc++;
            end else begin
                g = -1;
                for (int k = 1; k <= NV; k++)
                    if (g < 0 && mq[(m_rr + k) % NV].size() > 0) g = (m_rr + k) % NV;
                m_bc = 1;
            end
            m_rr = g;
            m_gv = g;
            m_xfer = m_xfer + 5'd1;
            r.vc   = g[VW-1:0];
            r.data = mq[g].pop_front();
            r.cnt  = m_xfer;
            exp_q.push_back(r);
        end
    endtask

    task automatic new_scenario();
        push_log.delete();
        pop_cyc.delete();
        pops = 0;
        viol = 0;
    endtask

    task automatic drain(input int budget, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (!(!model_has_words() && srcq[0].size() == 0 && srcq[1].size() == 0 &&
                 srcq[2].size() == 0 && srcq[3].size() == 0 &&
                 busy == 1'b0 && dst_push == 1'b0 && pop_prev == '0)) begin
            if (n >= budget) begin
                ok = 1'b0;
                break;
            end
            tick();
            n++;
        end
        repeat (2) tick();
        m_bc = BM;
    endtask

    task automatic wait_pop(input int budget, output bit ok);
        int n = 0;
        ok = 1'b1;
        do begin
            tick();
            n++;
        end while (src_pop == '0 && n < budget);
        if (src_pop == '0) ok = 1'b0;
    endtask

    task automatic reset_assert();
        reset = 1'b0;
        #2;
        for (int i = 0; i < NV; i++) begin
            srcq[i].delete();
            mq[i].delete();
        end
        src_empty = '1;
        pop_prev  = '0;
        m_rr = NV - 1;
        m_gv = 0;
        m_bc = 0;
        m_xfer = '0;
    endtask

    task automatic reset_release();
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        m_bc = BM;
    endtask

    task automatic test_reset();
        new_scenario();
        enable = 1'b1;
        dst_almost_full = 1'b0;
        reset_assert();
        total++;
        if ({src_pop, dst_push, dst_data, grant_vc, busy, xfer_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got pop=%b push=%b data=%h gv=%0d busy=%b cnt=%0d want all 0",
                     src_pop, dst_push, dst_data, grant_vc, busy, xfer_count);
        end
        reset_release();
        repeat (20) tick();
        total++;
        if (pops !== 0) begin
            bad++;
            $display("FAIL reset_no_pop got %0d pops want 0", pops);
        end
        total++;
        if ({busy, dst_push, xfer_count} !== '0) begin
            bad++;
            $display("FAIL reset_idle got busy=%b push=%b cnt=%0d want 0", busy, dst_push, xfer_count);
        end
    endtask

    task automatic test_single_vc();
        bit ok;
        new_scenario();
        load(1, 12'h111);
        load(1, 12'h112);
        load(1, 12'h113);
        model_predict();
        drain(100, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL single_timeout got busy=%b want drained", busy); end
        total++;
        if (push_log.size() !== 3) begin
            bad++;
            $display("FAIL single_count got %0d pushes want 3", push_log.size());
        end
        for (int i = 0; i < exp_q.size() && i < push_log.size(); i++) begin
            total++;
            if (push_log[i] !== exp_q[i] || push_log[i].data !== 12'h111 + LS'(i) || push_log[i].vc !== 2'd1) begin
                bad++;
                $display("FAIL single_push[%0d] got vc=%0d data=%h cnt=%0d want vc=%0d data=%h cnt=%0d", i,
                         push_log[i].vc, push_log[i].data, push_log[i].cnt, exp_q[i].vc, exp_q[i].data, exp_q[i].cnt);
            end
        end
        for (int i = 1; i < pop_cyc.size(); i++) begin
            total++;
            if (pop_cyc[i] - pop_cyc[i-1] !== 4) begin
                bad++;
                $display("FAIL single_spacing[%0d] got %0d cycles want 4", i, pop_cyc[i] - pop_cyc[i-1]);
            end
        end
        total++;
        if (xfer_count !== 5'd3 || grant_vc !== 2'd1) begin
            bad++;
            $display("FAIL single_final got cnt=%0d gv=%0d want cnt=3 gv=1", xfer_count, grant_vc);
        end
        total++;
        if (viol !== 0) begin bad++; $display("FAIL single_rules got %0d violations want 0", viol); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int order [16] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3};
        reset_assert();
        reset_release();
        new_scenario();
        for (int v = 0; v < NV; v++)
            for (int w = 0; w < 4; w++) load(v, LS'({v[1:0], w[1:0], 8'($urandom)}));
        model_predict();
        drain(200, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL rr_timeout got busy=%b want drained", busy); end
        total++;
        if (push_log.size() !== 16) begin
            bad++;
            $display("FAIL rr_count got %0d pushes want 16", push_log.size());
        end
        for (int i = 0; i < exp_q.size() && i < push_log.size(); i++) begin
            total++;
            if (push_log[i] !== exp_q[i] || int'(push_log[i].vc) !== order[i]) begin
                bad++;
                $display("FAIL rr_push[%0d] got vc=%0d data=%h cnt=%0d want vc=%0d data=%h cnt=%0d", i,
                         push_log[i].vc, push_log[i].data, push_log[i].cnt, order[i], exp_q[i].data, exp_q[i].cnt);
            end
        end
        total++;
        if (viol !== 0) begin bad++; $display("FAIL rr_rules got %0d violations want 0", viol); end
    endtask

    task automatic test_almost_full();
        bit ok;
        int pops_before;
        new_scenario();
        load(2, LS'($urandom));
        load(2, LS'($urandom));
        model_predict();
        wait_pop(20, ok);
        dst_almost_full = 1'b1;
        pops_before = pops;
        repeat (12) tick();
        total++;
        if (ok !== 1'b1 || push_log.size() !== 1) begin
            bad++;
            $display("FAIL af_inflight got %0d pushes (start=%b) want 1", push_log.size(), ok);
        end
        total++;
        if (pops !== pops_before) begin
            bad++;
            $display("FAIL af_hold got %0d pops want %0d", pops, pops_before);
        end
        dst_almost_full = 1'b0;
        tick();
        total++;
        if (src_pop !== 4'b0100) begin
            bad++;
            $display("FAIL af_resume got pop=%b want 0100", src_pop);
        end
        drain(100, ok);
        total++;
        if (ok !== 1'b1 || push_log.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL af_count got %0d pushes want %0d", push_log.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < push_log.size(); i++) begin
            total++;
            if (push_log[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL af_push[%0d] got vc=%0d data=%h cnt=%0d want vc=%0d data=%h cnt=%0d", i,
                         push_log[i].vc, push_log[i].data, push_log[i].cnt, exp_q[i].vc, exp_q[i].data, exp_q[i].cnt);
            end
        end
        total++;
        if (viol !== 0) begin bad++; $display("FAIL af_rules got %0d violations want 0", viol); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        new_scenario();
        for (int w = 0; w < 3; w++) load(1, LS'($urandom));
        model_predict();
        wait_pop(20, ok);
        tick();
        enable = 1'b0;
        repeat (12) tick();
        total++;
        if (ok !== 1'b1 || push_log.size() !== 1 || busy !== 1'b0 || pops !== 1) begin
            bad++;
            $display("FAIL en_stop got pushes=%0d busy=%b pops=%0d want 1/0/1", push_log.size(), busy, pops);
        end
        enable = 1'b1;
        tick();
        total++;
        if (src_pop !== (4'b0001 << exp_q[1].vc)) begin
            bad++;
            $display("FAIL en_resume got pop=%b want vc %0d", src_pop, exp_q[1].vc);
        end
        drain(100, ok);
        total++;
        if (ok !== 1'b1 || push_log.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL en_count got %0d pushes want %0d", push_log.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < push_log.size(); i++) begin
            total++;
            if (push_log[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL en_push[%0d] got vc=%0d data=%h cnt=%0d want vc=%0d data=%h cnt=%0d", i,
                         push_log[i].vc, push_log[i].data, push_log[i].cnt, exp_q[i].vc, exp_q[i].data, exp_q[i].cnt);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int n = 0;
        new_scenario();
        for (int v = 0; v < NV; v++)
            repeat ($urandom_range(0, 6)) load(v, LS'($urandom));
        load($urandom_range(0, NV - 1), LS'($urandom));
        model_predict();
        while (push_log.size() < exp_q.size() && n < 1500) begin
            enable = ($urandom_range(0, 3) != 0);
            dst_almost_full = ($urandom_range(0, 3) == 0);
            tick();
            n++;
        end
        enable = 1'b1;
        dst_almost_full = 1'b0;
        drain(300, ok);
        total++;
        if (ok !== 1'b1 || push_log.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL rand_count got %0d pushes want %0d", push_log.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < push_log.size(); i++) begin
            total++;
            if (push_log[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL rand_push[%0d] got vc=%0d data=%h cnt=%0d want vc=%0d data=%h cnt=%0d", i,
                         push_log[i].vc, push_log[i].data, push_log[i].cnt, exp_q[i].vc, exp_q[i].data, exp_q[i].cnt);
            end
        end
        total++;
        if (viol !== 0) begin bad++; $display("FAIL rand_rules got %0d violations want 0", viol); end
    endtask

    task automatic test_reset_mid_and_wrap();
        bit ok;
        new_scenario();
        load(3, LS'($urandom));
        load(3, LS'($urandom));
        wait_pop(20, ok);
        tick();
        reset_assert();
        total++;
        if (ok !== 1'b1 || {src_pop, dst_push, dst_data, grant_vc, busy, xfer_count} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got pop=%b push=%b data=%h gv=%0d busy=%b cnt=%0d want all 0",
                     src_pop, dst_push, dst_data, grant_vc, busy, xfer_count);
        end
        reset_release();
        new_scenario();
        load(3, LS'($urandom));
        load(0, LS'($urandom));
        for (int w = 0; w < 31; w++) load($urandom_range(0, NV - 1), LS'($urandom));
        model_predict();
        drain(400, ok);
        total++;
        if (ok !== 1'b1 || push_log.size() !== 33) begin
            bad++;
            $display("FAIL wrap_count got %0d pushes want 33", push_log.size());
        end
        total++;
        if (push_log.size() > 0 && push_log[0].vc !== 2'd0) begin
            bad++;
            $display("FAIL midreset_first_vc got %0d want 0", push_log[0].vc);
        end
        total++;
        if (push_log.size() > 31 && (push_log[30].cnt !== 5'd31 || push_log[31].cnt !== 5'd0)) begin
            bad++;
            $display("FAIL wrap_boundary got %0d then %0d want 31 then 0", push_log[30].cnt, push_log[31].cnt);
        end
        for (int i = 0; i < exp_q.size() && i < push_log.size(); i++) begin
            total++;
            if (push_log[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL wrap_push[%0d] got vc=%0d data=%h cnt=%0d want vc=%0d data=%h cnt=%0d", i,
                         push_log[i].vc, push_log[i].data, push_log[i].cnt, exp_q[i].vc, exp_q[i].data, exp_q[i].cnt);
            end
        end
        total++;
        if (viol !== 0) begin bad++; $display("FAIL wrap_rules got %0d violations want 0", viol); end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        dst_almost_full = 1'b0;
        src_empty = '1;
        src_data = '0;
        #2;
        test_reset();
        test_single_vc();
        test_round_robin();
        test_almost_full();
        test_enable_drop();
        test_random();
        test_reset_mid_and_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
